// File: rtl/pmem_arbiter.sv
// Shares one cacheline physical-memory port between the I-cache and D-cache miss paths.
// D-cache wins ties; a saturating streak counter forces an I grant after MAX_D_STREAK tie wins.
module pmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       d_req, tie, favour_i;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    d_req    = d_read | d_write;
    tie      = d_req & i_read;
    favour_i = tie & (streak_q == MAX_STREAK);
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (favour_i) begin
          state_d  = GRANT_I;
          streak_d = '0;
        end else if (d_req) begin
          state_d = GRANT_D;
          if (!i_read)                    streak_d = '0;
          else if (streak_q != MAX_STREAK) streak_d = streak_q + 4'd1;
        end else if (i_read) begin
          state_d  = GRANT_I;
          streak_d = '0;
        end
      end
      // Requests are not re-sampled while granted; only mem_resp ends the grant.
      GRANT_I, GRANT_D: if (mem_resp) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments; reset is synchronous, sampled at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      GRANT_I: begin
        mem_read = i_read;
        mem_addr = i_addr;
        i_resp   = mem_resp;
      end
      GRANT_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign arb_busy = (state_q != IDLE);

  // Protocol checks on the cache and memory sides; not part of the datapath.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(d_read && d_write))
        else $error("pmem_arbiter: d_read and d_write both high");
      if (state_q == GRANT_I)
        assert (i_read) else $error("pmem_arbiter: i_read dropped during grant");
      if (state_q == GRANT_D)
        assert (d_read || d_write) else $error("pmem_arbiter: d request dropped during grant");
      if (state_q == IDLE)
        assert (!mem_resp) else $warning("pmem_arbiter: mem_resp while idle ignored");
    end
  end

endmodule
